// File: rtl/clk_rst_seq_if.sv
// clk_rst_seq_if: bundle of the run control, divisor/mode configuration and
// sequencer outputs for clk_rst_seq.
//   master : drives run_i, div_i, mode_i; observes rst_out, ch_o, cycles_o, done_o
//   slave  : the sequencer itself (inputs/outputs mirrored)
// Parameters NCH, DIV_W and CNT_W must match the attached clk_rst_seq instance.
interface clk_rst_seq_if #(
  parameter int NCH   = 4,
  parameter int DIV_W = 8,
  parameter int CNT_W = 16
) ();
  logic                   run_i;
  logic [NCH*DIV_W-1:0]   div_i;
  logic [NCH-1:0]         mode_i;
  logic                   rst_out;
  logic [NCH-1:0]         ch_o;
  logic [CNT_W-1:0]       cycles_o;
  logic                   done_o;

  modport master (
    output run_i, div_i, mode_i,
    input  rst_out, ch_o, cycles_o, done_o
  );

  modport slave (
    input  run_i, div_i, mode_i,
    output rst_out, ch_o, cycles_o, done_o
  );
endinterface

// File: rtl/clk_rst_seq.sv
// clk_rst_seq: on-chip reset stretcher and clock-enable generator.
// After reset is released, rst_out is held for RST_CYCLES+1 further edges,
// then NCH divided enable channels run (pulse tick or 50% square wave per
// channel) while a run-cycle counter advances; once STOP_CYCLES run cycles
// have elapsed the block parks in DONE with all channels low.
// Ports:
//   clk    : system clock, rising edge
//   reset  : synchronous active-low reset
//   bus    : clk_rst_seq_if.slave
//            run_i (count enable), div_i (per-channel divisor),
//            mode_i (0 pulse / 1 toggle), rst_out, ch_o, cycles_o, done_o
module clk_rst_seq #(
  parameter int NCH         = 4,
  parameter int DIV_W       = 8,
  parameter int RST_CYCLES  = 3,
  parameter int STOP_CYCLES = 100,
  parameter int CNT_W       = 16
) (
  input  logic          clk,
  input  logic          reset,
  clk_rst_seq_if.slave  bus
);

  localparam logic [7:0]       RST_V  = 8'(RST_CYCLES);
  localparam logic [CNT_W-1:0] STOP_V = CNT_W'(STOP_CYCLES);

  typedef enum logic [1:0] {HOLD, RUN, DONE} state_t;

  state_t             state_q, state_d;
  logic [7:0]         hold_q;
  logic [CNT_W-1:0]   cycles_q;
  logic [CNT_W-1:0]   cycles_inc;
  logic               rst_q;
  logic               done_q;
  logic               count_en;
  logic [NCH-1:0]     mode_q;
  logic [NCH-1:0]     ch_q;
  logic [DIV_W-1:0]   cnt_q [NCH];

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= HOLD;
    else        state_q <= state_d;
  end

  // Next-state decode
  always_comb begin
    state_d    = state_q;
    count_en   = 1'b0;
    cycles_inc = cycles_q + CNT_W'(1);
    case (state_q)
      HOLD: begin
        if (hold_q == 8'd0) state_d = RUN;
      end
      RUN: begin
        count_en = bus.run_i;
        // A zero stop count disables DONE, letting cycles_o wrap freely.
        if (bus.run_i && (STOP_CYCLES != 0) && (cycles_inc == STOP_V))
          state_d = DONE;
      end
      DONE:    state_d = DONE;
      default: state_d = HOLD;
    endcase
  end

  // Hold countdown, run-cycle counter and registered status outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      hold_q   <= RST_V;
      cycles_q <= '0;
      rst_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      if (state_q == HOLD && hold_q != 8'd0) hold_q <= hold_q - 8'd1;
      if (count_en) cycles_q <= cycles_inc;
      rst_q  <= (state_d == HOLD);
      done_q <= (state_d == DONE);
    end
  end

  // Channel dividers
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode_q <= '0;
      ch_q   <= '0;
      for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
    end else begin
      // mode_q tracks mode_i in every state so HOLD leaves it in sync.
      mode_q <= bus.mode_i;
      for (int i = 0; i < NCH; i++) begin
        if (state_q != RUN || state_d == DONE) begin
          cnt_q[i] <= '0;
          ch_q[i]  <= 1'b0;
        end else if (bus.mode_i[i] != mode_q[i]) begin
          // Mode switch restarts the channel and beats a coincident event.
          cnt_q[i] <= '0;
          ch_q[i]  <= 1'b0;
        end else if (bus.run_i) begin
          // >= rather than == so a divisor lowered below the current count
          // fires on the next edge instead of wrapping the counter.
          if (cnt_q[i] >= bus.div_i[i*DIV_W +: DIV_W]) begin
            cnt_q[i] <= '0;
            ch_q[i]  <= mode_q[i] ? ~ch_q[i] : 1'b1;
          end else begin
            cnt_q[i] <= cnt_q[i] + DIV_W'(1);
            if (!mode_q[i]) ch_q[i] <= 1'b0;
          end
        end else if (!mode_q[i]) begin
          ch_q[i] <= 1'b0;
        end
      end
    end
  end

  assign bus.rst_out  = rst_q;
  assign bus.ch_o     = ch_q;
  assign bus.cycles_o = cycles_q;
  assign bus.done_o   = done_q;

endmodule

// File: tb/tb_clk_rst_seq.sv
module tb_clk_rst_seq;

  logic clk;
  logic reset;
  int   nvec;
  int   nerr;

  clk_rst_seq_if #(.NCH(4), .DIV_W(8), .CNT_W(16)) ifa ();
  clk_rst_seq_if #(.NCH(1), .DIV_W(8), .CNT_W(4))  ifb ();

  clk_rst_seq #(.NCH(4), .DIV_W(8), .RST_CYCLES(3), .STOP_CYCLES(100), .CNT_W(16))
    dut_a (.clk(clk), .reset(reset), .bus(ifa));

  clk_rst_seq #(.NCH(1), .DIV_W(8), .RST_CYCLES(3), .STOP_CYCLES(0), .CNT_W(4))
    dut_b (.clk(clk), .reset(reset), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nvec++;
    assert (got === exp) else begin
      nerr++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rst"},    32'(ifa.rst_out),  32'd1);
    chk({tag, "_ch"},     32'(ifa.ch_o),     32'd0);
    chk({tag, "_cycles"}, 32'(ifa.cycles_o), 32'd0);
    chk({tag, "_done"},   32'(ifa.done_o),   32'd0);
  endtask

  task automatic hold_release(input string tag);
    reset = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk({tag, "_hold_rst"}, 32'(ifa.rst_out), 32'd1);
      chk({tag, "_hold_ch"},  32'(ifa.ch_o),    32'd0);
    end
    tick();
    chk({tag, "_rel_rst"},    32'(ifa.rst_out),  32'd0);
    chk({tag, "_rel_cycles"}, 32'(ifa.cycles_o), 32'd0);
    chk({tag, "_rel_ch"},     32'(ifa.ch_o),     32'd0);
  endtask

  initial begin
    logic [3:0] e;
    nvec = 0;
    nerr = 0;
    reset      = 1'b0;
    ifa.run_i  = 1'b1;
    ifa.div_i  = {8'd3, 8'd2, 8'd1, 8'd0};
    ifa.mode_i = 4'b0000;
    ifb.run_i  = 1'b1;
    ifb.div_i  = 8'd0;
    ifb.mode_i = 1'b0;

    // Reset held for three edges, then released
    tick(); tick(); tick();
    chk_reset_vals("init");
    hold_release("init");

    // Pulse dividers {3,2,1,0}; dut_b wraps its 4-bit counter 15 -> 0
    for (int n = 1; n <= 16; n++) begin
      tick();
      e = {(n % 4 == 0), (n % 3 == 0), (n % 2 == 0), 1'b1};
      chk("pulse_ch", 32'(ifa.ch_o), 32'(e));
      chk("pulse_cycles", 32'(ifa.cycles_o), 32'(n));
      chk("wrap_cycles", 32'(ifb.cycles_o), 32'(n % 16));
      chk("wrap_done", 32'(ifb.done_o), 32'd0);
    end

    // Channel 1 to toggle mode: cleared on 17, first toggle on 19
    ifa.mode_i = 4'b0010;
    for (int n = 17; n <= 24; n++) begin
      tick();
      e = {(n % 4 == 0), (n % 3 == 0), (n >= 19) && (((n - 19) / 2) % 2 == 0), 1'b1};
      chk("toggle_ch", 32'(ifa.ch_o), 32'(e));
    end

    // Pause: toggle level held, pulses low, counter frozen
    ifa.run_i = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("pause_ch", 32'(ifa.ch_o), 32'b0010);
      chk("pause_cycles", 32'(ifa.cycles_o), 32'd24);
    end

    // Resume: phase continues
    ifa.run_i = 1'b1;
    for (int n = 25; n <= 28; n++) begin
      tick();
      e = {(n % 4 == 0), (n % 3 == 0), (((n - 19) / 2) % 2 == 0), 1'b1};
      chk("resume_ch", 32'(ifa.ch_o), 32'(e));
      chk("resume_cycles", 32'(ifa.cycles_o), 32'(n));
    end

    // Channel 0 divisor 7: count reaches 5 after edge 33
    ifa.div_i[7:0] = 8'd7;
    for (int n = 29; n <= 33; n++) begin
      tick();
      chk("div7_ch0", 32'(ifa.ch_o[0]), 32'd0);
    end
    // Lower to 2: event immediately, then every 3
    ifa.div_i[7:0] = 8'd2;
    for (int n = 34; n <= 40; n++) begin
      tick();
      chk("div2_ch0", 32'(ifa.ch_o[0]), 32'((n - 34) % 3 == 0));
    end
    // Flip channel 0 to toggle right after an event: cleared, then toggles on 44
    ifa.mode_i = 4'b0011;
    for (int n = 41; n <= 44; n++) begin
      tick();
      chk("modeflip_ch0", 32'(ifa.ch_o[0]), 32'(n == 44));
    end

    // Run to the stop count
    for (int n = 45; n <= 99; n++) tick();
    chk("pre_stop_cycles", 32'(ifa.cycles_o), 32'd99);
    chk("pre_stop_done", 32'(ifa.done_o), 32'd0);
    tick();
    chk("stop_cycles", 32'(ifa.cycles_o), 32'd100);
    chk("stop_done", 32'(ifa.done_o), 32'd1);
    chk("stop_ch", 32'(ifa.ch_o), 32'd0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_cycles", 32'(ifa.cycles_o), 32'd100);
      chk("done_done", 32'(ifa.done_o), 32'd1);
      chk("done_ch", 32'(ifa.ch_o), 32'd0);
      chk("done_rst", 32'(ifa.rst_out), 32'd0);
    end

    // Reset out of DONE, then reset again at run cycle 37
    reset = 1'b0;
    tick();
    chk_reset_vals("done_reset");
    hold_release("rerun");
    for (int n = 1; n <= 37; n++) tick();
    chk("run37_cycles", 32'(ifa.cycles_o), 32'd37);
    reset = 1'b0;
    tick();
    chk_reset_vals("mid_reset");
    hold_release("mid");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/clk_rst_seq.md
# clk_rst_seq

Synthesizable clock-enable and reset sequencer that replaces ad-hoc bench-side clock/reset stimulus with a parametrised on-chip block. It stretches and synchronously releases a system reset, then drives NCH independently divided enable channels, each selectable as a single-cycle tick or a 50 % square wave. A run-cycle counter asserts a stop/done flag after a fixed number of cycles. It sits at the top of the design and feeds every downstream block's reset and enables.

## Interface
- NCH, 4, number of output channels (1..16)
- DIV_W, 8, width of each channel divisor
- RST_CYCLES, 3, extra cycles rst_out stays high after reset releases (0..255)
- STOP_CYCLES, 100, run cycles before done_o; 0 = never stop
- CNT_W, 16, width of cycles_o

- clk  in  1  single system clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset: reset==0 at a rising edge resets the block
- run_i  in  1  1 = count, 0 = pause all counters
- div_i  in  NCH*DIV_W  per-channel divisor d; channel i uses bits [i*DIV_W +: DIV_W]
- mode_i  in  NCH  per channel: 0 = pulse tick, 1 = square toggle
- rst_out  out  1  active-high stretched reset for downstream logic
- ch_o  out  NCH  channel outputs (registered)
- cycles_o  out  CNT_W  counted run cycles
- done_o  out  1  high once STOP_CYCLES run cycles have elapsed

## Operation
- States: HOLD, RUN, DONE. Reset forces HOLD.
- Reset values: rst_out=1, ch_o=0, cycles_o=0, done_o=0, hold counter h=RST_CYCLES, all channel counters 0.
- HOLD: each edge with reset==1: if h==0, go to RUN and clear rst_out; else h<=h-1. rst_out therefore falls after RST_CYCLES+1 edges with reset high. Channels and cycles_o are idle.
- RUN, run_i==1: cycles_o increments. Each channel counter c counts. When c>=d, c<=0 and a channel event fires; otherwise c<=c+1.
- Pulse mode: ch_o[i]=1 for exactly the cycle after an event edge, else 0. Toggle mode: ch_o[i] inverts on each event edge.
- Period is d+1 counting cycles.
  - d=0, pulse mode: ch_o constant 1.
  - d=0, toggle mode: ch_o toggles every cycle.
- Divisor change mid-count: the compare uses the new d immediately. If c already exceeds the new d, the event fires on the next counting edge.
- Mode change on a channel: the edge after mode_i[i] differs from its registered copy clears that channel's c and ch_o[i] to 0. Counting restarts from there.
- RUN, run_i==0: all counters freeze and cycles_o holds. Pulse-mode outputs go to 0; toggle-mode outputs hold their level.
- If STOP_CYCLES!=0 and cycles_o reaches STOP_CYCLES, the block goes to DONE.
  - DONE: done_o=1, cycles_o holds at STOP_CYCLES, ch_o=0, rst_out stays 0. DONE is left only by reset.
- If STOP_CYCLES==0, done_o stays 0 and cycles_o wraps modulo 2^CNT_W.
- Reset from any state, mid-count included, returns the block to reset values on that same edge.

## Timing
- All outputs are registered; no combinational input-to-output path.
- Reset latency: outputs take their reset values after the first edge sampling reset==0.
- First counting edge is the edge after rst_out falls, if run_i==1.
- Pulse-mode channel with divisor d and run_i held at 1: the first ch_o pulse is visible after d+1 counting edges, then one pulse every d+1 cycles.
- done_o rises on the same edge on which cycles_o becomes STOP_CYCLES.
- Simultaneous event and mode change on one channel: the mode change wins and ch_o is cleared.
- Simultaneous run_i fall and event edge: run_i is sampled on that edge, so no event fires.

## Test plan
- Reset release: reset=0 for 3 edges, then 1, RST_CYCLES=3 -> rst_out=1 through 4 edges with reset high, 0 after the 4th; ch_o=0 and cycles_o=0 throughout.
- Pulse dividers: div = {3,2,1,0}, mode=0, run_i=1 -> ch3 period 4, ch2 period 3, ch1 period 2, ch0 constant 1; the first ch3 pulse follows the 4th counting edge.
- Toggle and pause: ch1 mode=1 with d=1 -> ch_o[1] toggles every 2 cycles. Drop run_i for 5 cycles -> ch_o[1] level held and cycles_o frozen. Resume -> the phase continues unchanged.
- Mid-count changes: ch0 d=7 with c=5, set d=2 -> event on the next edge, then period 3. Flip mode_i[0] -> ch_o[0]=0 and c=0 on the next edge.
- Stop: STOP_CYCLES=100 -> done_o rises exactly when cycles_o=100, ch_o=0 afterwards and cycles_o stays 100. STOP_CYCLES=0, CNT_W=4 -> cycles_o wraps 15->0 and done_o stays 0.
- Mid-operation reset: assert reset=0 at cycle 37 of RUN -> all outputs take reset values on that edge, and the full HOLD sequence repeats on release.
